// File: rtl/simple_pkg.sv
// Shared types and constants for the bit-serializer front end.
// No logic, no latency.
// No flow control; types only.
package simple_pkg;

  // Serializer control state: waiting for a word, or shifting one out
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Default parallel word width
  localparam int SER_DATA_W = 8;

endpackage

// File: rtl/simple_bit_serializer.sv
// Parallel-to-serial converter: DATA_W-bit words in, one bit per BIT_EN step out.
// Latency: word accepted at edge k shows its first bit after edge k+1.
// Backpressure: one-word holding register; DIN_READY = !HOLD_VLD.
module simple_bit_serializer
  import simple_pkg::*;
#(
  parameter int DATA_W    = SER_DATA_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic              BIT_EN,
  output logic              SOUT,
  output logic              SOUT_VALID,
  output logic              WORD_DONE
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              word_done_q, word_done_d;

  logic in_shift;
  logic last_bit;
  logic shift_step;
  logic load;
  logic accept;

  // Step qualifiers decoded from current state and the advance strobe.
  // A count of one or less is treated as the last bit so a corrupted
  // count can never strand the shifter.
  always_comb begin
    in_shift   = (state_q == SER_SHIFT);
    last_bit   = in_shift && BIT_EN && (cnt_q <= CNT_ONE);
    shift_step = in_shift && BIT_EN && (cnt_q > CNT_ONE);
    load       = hold_vld_q && ((state_q == SER_IDLE) || last_bit);
    accept     = DIN_VALID && !hold_vld_q;
  end

  // All state flops; async reset discards any partial and held word
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= SER_IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  // Next state: leave IDLE when a word is held, return once the last bit
  // goes with nothing queued behind it
  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE:  if (hold_vld_q) state_d = SER_SHIFT;
      SER_SHIFT: if (last_bit && !hold_vld_q) state_d = SER_IDLE;
      default:   state_d = SER_IDLE;
    endcase
  end

  // Datapath: load/shift the shift register and fill the holding register.
  // Accept and drain are mutually exclusive because accept needs the
  // holding register empty while drain needs it full.
  always_comb begin
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    word_done_d = last_bit;
    if (load) begin
      shreg_d    = hold_q;
      cnt_d      = CNT_FULL;
      hold_vld_d = 1'b0;
    end else if (shift_step) begin
      if (MSB_FIRST) shreg_d = shreg_q << 1;
      else           shreg_d = shreg_q >> 1;
      cnt_d = cnt_q - CNT_ONE;
    end else if (last_bit) begin
      cnt_d = '0;
    end
    if (accept) begin
      hold_d     = DIN;
      hold_vld_d = 1'b1;
    end
  end

  // Outputs decoded purely from registers
  always_comb begin
    SOUT       = IDLE_LVL;
    SOUT_VALID = 1'b0;
    if (state_q == SER_SHIFT) begin
      SOUT       = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
      SOUT_VALID = 1'b1;
    end
    DIN_READY = !hold_vld_q;
    WORD_DONE = word_done_q;
  end

endmodule

// File: tb/tb_simple_bit_serializer.sv
// Self-checking bench for simple_bit_serializer.
// Two instances share inputs: MSB-first/idle-low and LSB-first/idle-high.
// Outputs are compared every cycle against a word/bit-index reference model.
module tb_simple_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_vld;
  logic       bit_en;

  logic a_rdy, a_sout, a_vld, a_wd;
  logic b_rdy, b_sout, b_vld, b_wd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simple_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_a (
    .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_vld), .DIN_READY(a_rdy),
    .BIT_EN(bit_en), .SOUT(a_sout), .SOUT_VALID(a_vld), .WORD_DONE(a_wd)
  );

  simple_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_b (
    .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_vld), .DIN_READY(b_rdy),
    .BIT_EN(bit_en), .SOUT(b_sout), .SOUT_VALID(b_vld), .WORD_DONE(b_wd)
  );

  // Reference model: current word plus index of the bit on the line
  // (-1 when nothing is being sent) and a one-entry pending word.
  int         m_pos;
  logic [7:0] m_cur;
  logic [7:0] m_hold;
  bit         m_hold_v;
  bit         m_wd;

  function automatic logic [3:0] av();
    return {a_sout, a_vld, a_rdy, a_wd};
  endfunction

  function automatic logic [3:0] bv();
    return {b_sout, b_vld, b_rdy, b_wd};
  endfunction

  function automatic logic m_bit(bit msb_first, bit idle);
    if (m_pos < 0) return idle;
    return msb_first ? m_cur[7 - m_pos] : m_cur[m_pos];
  endfunction

  function automatic logic [3:0] m_vec(bit msb_first, bit idle);
    return {m_bit(msb_first, idle), (m_pos >= 0), !m_hold_v, m_wd};
  endfunction

  task automatic model_reset();
    m_pos    = -1;
    m_cur    = '0;
    m_hold   = '0;
    m_hold_v = 1'b0;
    m_wd     = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    acc  = din_vld && !m_hold_v;
    m_wd = 1'b0;
    if (m_pos < 0) begin
      if (m_hold_v) begin
        m_cur = m_hold; m_pos = 0; m_hold_v = 1'b0;
      end
    end else if (bit_en) begin
      if (m_pos == 7) begin
        m_wd = 1'b1;
        if (m_hold_v) begin
          m_cur = m_hold; m_pos = 0; m_hold_v = 1'b0;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos = m_pos + 1;
      end
    end
    if (acc) begin
      m_hold = din; m_hold_v = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // One clock: inputs are already driven; model follows the edge, then
  // both DUTs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    chk("model_a", 16'(av()), 16'(m_vec(1'b1, 1'b0)));
    chk("model_b", 16'(bv()), 16'(m_vec(1'b0, 1'b1)));
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       en;
    logic [3:0] want;  // {SOUT, SOUT_VALID, DIN_READY, WORD_DONE} of u_a
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0]  seq8a, seq8b;
    logic [15:0] seq16;
    logic        prev;
    int          vcnt, changes, wdc;

    // 8'h98 MSB-first with BIT_EN held high, one row per cycle
    tbl[0]  = '{1'b1, 8'h98, 1'b1, 4'b0000};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 4'b1110};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 4'b0110};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 4'b0110};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 4'b1110};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 4'b1110};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 4'b0110};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 4'b0110};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 4'b0110};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 4'b0011};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 4'b0010};

    rst_n   = 1'b0;
    din     = '0;
    din_vld = 1'b0;
    bit_en  = 1'b1;
    model_reset();

    #1;
    chk("reset_a", 16'(av()), 16'(4'b0010));
    chk("reset_b", 16'(bv()), 16'(4'b1010));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_a", 16'(av()), 16'(4'b0010));
    chk("idle_b", 16'(bv()), 16'(4'b1010));

    // Table-driven single word
    for (int i = 0; i < 11; i++) begin
      din_vld = tbl[i].vld;
      din     = tbl[i].d;
      bit_en  = tbl[i].en;
      tick();
      chk($sformatf("vec%0d", i), 16'(av()), 16'(tbl[i].want));
    end

    // 8'h01 on both bit orders
    din_vld = 1'b1; din = 8'h01;
    tick();
    din_vld = 1'b0;
    seq8a = '0; seq8b = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seq8a = {seq8a[6:0], a_sout};
      seq8b = {seq8b[6:0], b_sout};
    end
    chk("msb_first_01", 16'(seq8a), 16'h0001);
    chk("lsb_first_01", 16'(seq8b), 16'h0080);
    tick();
    chk("lsb_word_done", 16'(b_wd), 16'h0001);
    tick();

    // Back-to-back 8'hA5, 8'h3C with DIN_VALID held
    din_vld = 1'b1; din = 8'hA5;
    tick();
    chk("b2b_rdy_after_acc", 16'(a_rdy), 16'h0000);
    seq16 = '0; vcnt = 0;
    tick();
    chk("b2b_rdy_after_load", 16'(a_rdy), 16'h0001);
    seq16 = {seq16[14:0], a_sout}; vcnt += int'(a_vld);
    din = 8'h3C;
    tick();
    chk("b2b_second_acc", 16'(a_rdy), 16'h0000);
    seq16 = {seq16[14:0], a_sout}; vcnt += int'(a_vld);
    din_vld = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      seq16 = {seq16[14:0], a_sout}; vcnt += int'(a_vld);
    end
    chk("b2b_bits", seq16, 16'hA53C);
    chk("b2b_valid_cycles", 16'(vcnt), 16'd16);
    tick();
    chk("b2b_end", 16'(av()), 16'(4'b0011));

    // 8'hF0 with BIT_EN alternating 0,1 after the load
    din_vld = 1'b1; din = 8'hF0; bit_en = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    vcnt = int'(a_vld); changes = 0; wdc = 0;
    for (int j = 1; j <= 20; j++) begin
      bit_en = (j % 2 == 0);
      prev   = a_sout;
      tick();
      vcnt += int'(a_vld);
      if (!bit_en && (a_sout !== prev)) changes++;
      wdc += int'(a_wd);
    end
    bit_en = 1'b1;
    chk("en_toggle_cycles", 16'(vcnt), 16'd16);
    chk("en_toggle_stable", 16'(changes), 16'd0);
    chk("en_toggle_done", 16'(wdc), 16'd1);

    // Reset after the third bit of 8'hFF with 8'h55 held
    din_vld = 1'b1; din = 8'hFF;
    tick();
    tick();
    din = 8'h55;
    tick();
    din_vld = 1'b0;
    tick();
    tick();
    chk("pre_reset_held", 16'(a_rdy), 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a", 16'(av()), 16'(4'b0010));
    chk("rst_mid_b", 16'(bv()), 16'(4'b1010));
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_vld || b_vld) vcnt++;
    end
    chk("post_rst_silent", 16'(vcnt), 16'd0);

    // Random traffic, strobes and occasional resets against the model
    for (int i = 0; i < 3000; i++) begin
      din_vld = ($urandom_range(0, 3) != 0);
      din     = 8'($urandom);
      bit_en  = ($urandom_range(0, 3) != 0);
      rst_n   = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    din_vld = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_bit_serializer.md
# simple_bit_serializer

Parallel-to-serial front end for the sequence-detector path. Accepts DATA_W-bit words over a valid/ready handshake and emits them as a one-bit-per-step serial stream. The serial output drives the detector's single-bit `IN` input directly, so with `BIT_EN` tied high the detector sees one new bit every clock. A one-word holding register lets back-to-back words stream with no idle bit between them.

## Interface
- `DATA_W`, default 8: word width; legal range 2..32.
- `MSB_FIRST`, default 1: 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- `IDLE_LVL`, default 0: level driven on `SOUT` while no word is shifting.
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RST_N` input, 1 bit: reset, asynchronous and active-low.
- `DIN` input, DATA_W bits: parallel word.
- `DIN_VALID` input, 1 bit: `DIN` holds a word.
- `DIN_READY` output, 1 bit: block can accept a word; registered, equals !HOLD_VLD.
- `BIT_EN` input, 1 bit: advance strobe; the serial stream moves one bit on each edge where it is 1.
- `SOUT` output, 1 bit: serial bit, connected to the detector's `IN`.
- `SOUT_VALID` output, 1 bit: `SOUT` carries a data bit.
- `WORD_DONE` output, 1 bit: one-cycle pulse after the last bit of a word is consumed.

## Operation
- **Internal state**
  - HOLD[DATA_W-1:0] and HOLD_VLD: one-word holding register.
  - SHREG[DATA_W-1:0]: shift register.
  - CNT: bits remaining, width clog2(DATA_W)+1.
  - State register: IDLE or SHIFT.
- **Accept:** on an edge with DIN_VALID && DIN_READY, HOLD <= DIN and HOLD_VLD <= 1. `DIN` is not sampled on any other edge.
- **IDLE**
  - `SOUT` = IDLE_LVL and `SOUT_VALID` = 0.
  - If HOLD_VLD: SHREG <= HOLD, HOLD_VLD <= 0, CNT <= DATA_W, go to SHIFT.
- **SHIFT**
  - `SOUT` = SHREG[DATA_W-1] when MSB_FIRST=1, else SHREG[0]. `SOUT_VALID` = 1.
  - On an edge with BIT_EN=1 and CNT>1: shift SHREG one position toward the output end (zero fill) and CNT <= CNT-1.
  - On an edge with BIT_EN=1 and CNT==1 (last bit consumed), WORD_DONE <= 1 and:
    - if HOLD_VLD: reload SHREG from HOLD, clear HOLD_VLD, CNT <= DATA_W, stay in SHIFT;
    - otherwise go to IDLE.
  - BIT_EN=0: all shift state holds. `SOUT` stays stable; the downstream stage is expected to sample only on BIT_EN cycles.
- **Accept/drain overlap:** `DIN_READY` is !HOLD_VLD only, so an accept and a drain of HOLD never happen on the same edge. This costs no throughput because DATA_W ≥ 2.
- **Reset:** asserting RST_N=0 at any time, including mid-word, clears everything; the partial word and any held word are discarded.
  - Reset values: `SOUT`=IDLE_LVL, `SOUT_VALID`=0, `DIN_READY`=1, `WORD_DONE`=0; state=IDLE, HOLD_VLD=0, CNT=0.
- **Illegal state encodings** recover to IDLE on the next edge.

## Timing
- **Word latency:** word accepted at edge k → first bit valid on `SOUT` after edge k+1 (state enters SHIFT at k+1).
- **Throughput:** with BIT_EN=1 continuously, each word occupies exactly DATA_W consecutive cycles. With HOLD refilled in time, consecutive words leave no gap.
- **DIN_READY:** drops the cycle after an accept. It rises the cycle after HOLD drains (the IDLE load edge or the last-bit edge).
- **WORD_DONE:** high for exactly one cycle, directly after the last-bit edge.
- **Outputs:** all registered or decoded from registers; no combinational path from `DIN`, `DIN_VALID` or `BIT_EN` to any output.

## Structure
- Shared package `simple_pkg`:
  - state enum SER_IDLE=1'b0, SER_SHIFT=1'b1;
  - default word-width constant SER_DATA_W=8.
- Flat module, no sub-module; the holding register and the shifter are each too small to justify one.
- System-level pairing: this block's `SOUT` → the detector's `IN`, with both blocks on the same clock.

## Test plan
- Reset release, idle for 5 cycles → `SOUT`=0, `SOUT_VALID`=0, `DIN_READY`=1, `WORD_DONE`=0.
- DATA_W=8, MSB_FIRST=1, BIT_EN=1, send 8'h98 → `SOUT` sequence 1,0,0,1,1,0,0,0 on cycles k+1..k+8. `WORD_DONE` high at cycle k+9. The downstream detector `MATCH` pulses once, one cycle after the fifth bit.
- Back-to-back 8'hA5, 8'h3C with DIN_VALID held high → 16 contiguous valid bits 10100101 00111100 with no gap. The second accept occurs on the edge after the first load.
- MSB_FIRST=0, send 8'h01 → first bit 1, then seven 0s.
- BIT_EN toggling 1,0,1,0 during 8'hF0 → each bit held across the BIT_EN=0 cycle. The word takes 16 cycles and `SOUT` never changes on a BIT_EN=0 edge.
- RST_N pulsed low after the third bit of 8'hFF, with 8'h55 held in HOLD → outputs return to reset values immediately. After release nothing is emitted until a new word is sent.
